// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multicycle main FSM and the RV32I datapath.
// The master side is the controller; the slave side is the datapath and memory.
interface multicycle_main_fsm_if;
  logic [6:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       PCUpdate;
  logic       Branch;
  logic       RegWrite;
  logic       MemWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       illegal_op;
  logic       bus_err;
  logic [3:0] state_dbg;

  modport master (
    input  op, mem_ready,
    output mem_req, PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_op, bus_err, state_dbg
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_op, bus_err, state_dbg
  );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core: one instruction phase per state,
// memory phases paced by mem_ready with a bounded wait that ends in bus_err.
module multicycle_main_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  multicycle_main_fsm_if.master  bus
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic          is_mem_state;
  logic          timeout;
  logic          op_known;

  assign is_mem_state = (state_reg == FETCH) || (state_reg == MEMREAD) || (state_reg == MEMWRITE);
  assign op_known = (bus.op == OP_LW) || (bus.op == OP_SW) || (bus.op == OP_R) ||
                    (bus.op == OP_I)  || (bus.op == OP_BEQ) || (bus.op == OP_JAL);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= FETCH;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // The counter only advances while stalled in a memory state; every exit clears it.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    timeout       = 1'b0;
    if (is_mem_state && !bus.mem_ready) begin
      if (wait_cnt_reg == WAIT_LAST) timeout = 1'b1;
      else                           wait_cnt_next = wait_cnt_reg + 1'b1;
    end
    case (state_reg)
      FETCH:    if (bus.mem_ready) state_next = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (bus.mem_ready) state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWRITE: if (bus.mem_ready) state_next = FETCH;
      EXECUTER, EXECUTEI, JAL: state_next = ALUWB;
      ALUWB, BEQ: state_next = FETCH;
      default:  state_next = FETCH;
    endcase
    if (timeout) state_next = FETCH;
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.PCUpdate   = 1'b0;
    bus.Branch     = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUOp      = 2'b00;
    bus.illegal_op = 1'b0;
    bus.bus_err    = 1'b0;
    bus.state_dbg  = 4'd0;
    if (reset_n) begin
      bus.state_dbg = state_reg;
      bus.bus_err   = timeout;
      case (state_reg)
        FETCH: begin
          bus.mem_req   = 1'b1;
          bus.ALUSrcB   = 2'b10;
          bus.ResultSrc = 2'b10;
          bus.IRWrite   = bus.mem_ready;
          bus.PCUpdate  = bus.mem_ready;
        end
        DECODE: begin
          bus.ALUSrcA    = 2'b01;
          bus.ALUSrcB    = 2'b01;
          bus.illegal_op = !op_known;
        end
        MEMADR: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
        end
        MEMREAD: begin
          bus.mem_req = 1'b1;
          bus.AdrSrc  = 1'b1;
        end
        MEMWB: begin
          bus.ResultSrc = 2'b01;
          bus.RegWrite  = 1'b1;
        end
        // The store strobe is withdrawn on the cycle the wait gives up.
        MEMWRITE: begin
          bus.mem_req  = 1'b1;
          bus.AdrSrc   = 1'b1;
          bus.MemWrite = !timeout;
        end
        EXECUTER: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUOp   = 2'b10;
        end
        EXECUTEI: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUSrcB = 2'b01;
          bus.ALUOp   = 2'b10;
        end
        ALUWB:    bus.RegWrite = 1'b1;
        BEQ: begin
          bus.ALUSrcA = 2'b10;
          bus.ALUOp   = 2'b01;
          bus.Branch  = 1'b1;
        end
        JAL: begin
          bus.ALUSrcA  = 2'b01;
          bus.ALUSrcB  = 2'b10;
          bus.PCUpdate = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: walks every instruction class, reset
// mid-access, ready stalls and both sides of the memory timeout boundary.
module tb_multicycle_main_fsm;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_main_fsm_if bus ();

  multicycle_main_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // {mem_req,PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,illegal_op,bus_err}
  logic [16:0] ctrl;
  assign ctrl = {bus.mem_req, bus.PCUpdate, bus.Branch, bus.RegWrite, bus.MemWrite, bus.IRWrite,
                 bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                 bus.illegal_op, bus.bus_err};

  localparam logic [16:0] C_ZERO     = 17'b0;
  localparam logic [16:0] C_FETCH_R  = {6'b110001, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [16:0] C_FETCH_W  = {6'b100000, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [16:0] C_FETCH_TO = {6'b100000, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01};
  localparam logic [16:0] C_DECODE   = {6'b000000, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
  localparam logic [16:0] C_DEC_ILL  = {6'b000000, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
  localparam logic [16:0] C_MEMADR   = {6'b000000, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
  localparam logic [16:0] C_MEMREAD  = {6'b100000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] C_MEMWB    = {6'b000100, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] C_MEMWRITE = {6'b100010, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] C_MW_TO    = {6'b100000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
  localparam logic [16:0] C_EXECR    = {6'b000000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [16:0] C_EXECI    = {6'b000000, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
  localparam logic [16:0] C_ALUWB    = {6'b000100, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [16:0] C_BEQ      = {6'b001000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
  localparam logic [16:0] C_JAL      = {6'b010000, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs change at posedge+1; outputs are sampled 1 time unit later.
  task automatic chk(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_ctrl);
    #1;
    checks++;
    assert (bus.state_dbg === exp_state && ctrl === exp_ctrl)
    else begin
      errors++;
      $error("FAIL %s state_dbg=%0d ctrl=%b required state_dbg=%0d ctrl=%b",
             tag, bus.state_dbg, ctrl, exp_state, exp_ctrl);
    end
    $display("check %s state_dbg=%0d ctrl=%b", tag, bus.state_dbg, ctrl);
  endtask

  initial begin
    reset_n = 1'b0; bus.op = 7'b0; bus.mem_ready = 1'b0;
    tick(); tick();
    chk("reset_idle", 4'd0, C_ZERO);

    // Store up to MEMWRITE, then reset mid-access
    reset_n = 1'b1; bus.op = 7'b0100011; bus.mem_ready = 1'b1;
    chk("sw_fetch", 4'd0, C_FETCH_R);
    tick(); chk("sw_decode", 4'd1, C_DECODE);
    tick(); chk("sw_memadr", 4'd2, C_MEMADR);
    tick(); bus.mem_ready = 1'b0; chk("sw_memwrite", 4'd5, C_MEMWRITE);
    reset_n = 1'b0; chk("rst_in_memwrite", 4'd0, C_ZERO);
    tick(); chk("rst_cycle2", 4'd0, C_ZERO);
    tick(); reset_n = 1'b1; chk("post_rst_fetch", 4'd0, C_FETCH_W);

    // FETCH stalled three cycles, ready on the fourth
    tick(); chk("fetch_wait2", 4'd0, C_FETCH_W);
    tick(); chk("fetch_wait3", 4'd0, C_FETCH_W);
    tick(); bus.mem_ready = 1'b1; bus.op = 7'b0000011; chk("fetch_ready4", 4'd0, C_FETCH_R);

    // lw: 0,1,2,3,4,0
    tick(); chk("lw_decode", 4'd1, C_DECODE);
    tick(); chk("lw_memadr", 4'd2, C_MEMADR);
    tick(); chk("lw_memread", 4'd3, C_MEMREAD);
    tick(); chk("lw_memwb", 4'd4, C_MEMWB);
    tick(); bus.op = 7'b0110011; chk("lw_done", 4'd0, C_FETCH_R);

    // R-type
    tick(); chk("r_decode", 4'd1, C_DECODE);
    tick(); chk("r_exec", 4'd6, C_EXECR);
    tick(); chk("r_aluwb", 4'd8, C_ALUWB);
    tick(); bus.op = 7'b1100011; chk("r_done", 4'd0, C_FETCH_R);

    // beq: 3-cycle loop
    tick(); chk("beq_decode", 4'd1, C_DECODE);
    tick(); chk("beq_beq", 4'd9, C_BEQ);
    tick(); bus.op = 7'b0010011; chk("beq_done", 4'd0, C_FETCH_R);

    // I-type
    tick(); chk("i_decode", 4'd1, C_DECODE);
    tick(); chk("i_exec", 4'd7, C_EXECI);
    tick(); chk("i_aluwb", 4'd8, C_ALUWB);
    tick(); bus.op = 7'b1101111; chk("i_done", 4'd0, C_FETCH_R);

    // jal
    tick(); chk("jal_decode", 4'd1, C_DECODE);
    tick(); chk("jal_jal", 4'd10, C_JAL);
    tick(); chk("jal_aluwb", 4'd8, C_ALUWB);
    tick(); bus.op = 7'b1111111; chk("jal_done", 4'd0, C_FETCH_R);

    // Unsupported opcode
    tick(); chk("ill_decode", 4'd1, C_DEC_ILL);
    tick(); bus.op = 7'b0100011; chk("ill_back_fetch", 4'd0, C_FETCH_R);

    // MEMWRITE timeout on the 16th stalled cycle
    tick(); chk("to_decode", 4'd1, C_DECODE);
    tick(); chk("to_memadr", 4'd2, C_MEMADR);
    tick(); bus.mem_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i < 16) begin
        chk($sformatf("to_wait%0d", i), 4'd5, C_MEMWRITE);
        tick();
      end else begin
        chk("to_bus_err", 4'd5, C_MW_TO);
      end
    end
    tick(); chk("to_fetch", 4'd0, C_FETCH_W);

    // Ready arriving at count 15 is a success
    bus.mem_ready = 1'b1; chk("edge_fetch", 4'd0, C_FETCH_R);
    tick(); chk("edge_decode", 4'd1, C_DECODE);
    tick(); chk("edge_memadr", 4'd2, C_MEMADR);
    tick(); bus.mem_ready = 1'b0;
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("edge_wait%0d", i), 4'd5, C_MEMWRITE);
      tick();
    end
    bus.mem_ready = 1'b1; chk("edge_ready16", 4'd5, C_MEMWRITE);
    tick(); bus.mem_ready = 1'b0; chk("edge_fetch_after", 4'd0, C_FETCH_W);

    // FETCH timeout retries FETCH with no IR/PC strobe; counter restarts
    for (int i = 2; i <= 16; i++) begin
      tick();
      if (i < 16) chk($sformatf("fto_wait%0d", i), 4'd0, C_FETCH_W);
      else        chk("fto_bus_err", 4'd0, C_FETCH_TO);
    end
    tick(); chk("fto_retry", 4'd0, C_FETCH_W);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
